// File: rtl/servo_move_scheduler_if.sv
// -----------------------------------------------------------------------------
// servo_move_scheduler_if
// Move-request handshake between game logic (master) and the servo move
// scheduler (slave).
//   req_valid  master -> slave  a move request is presented
//   req_ready  slave  -> master the request is taken on an edge with req_valid
//   req_idx    master -> slave  servo index
//   req_pos    master -> slave  target position bit for that servo
// -----------------------------------------------------------------------------
interface servo_move_scheduler_if #(
   parameter int IDX_W = 3
);
   logic             req_valid;
   logic             req_ready;
   logic [IDX_W-1:0] req_idx;
   logic             req_pos;

   modport master (
      output req_valid,
      output req_idx,
      output req_pos,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_idx,
      input  req_pos,
      output req_ready
   );
endinterface

// File: rtl/servo_move_scheduler.sv
// -----------------------------------------------------------------------------
// servo_move_scheduler
// Queues servo move requests in order and issues them one at a time onto the
// position vector for the PWM block. A moved servo stays busy for a fixed
// settle time, and no more than MAX_ACTIVE servos are busy together so the
// peak supply current stays bounded.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   req      request port (slave side): req_valid/req_ready/req_idx/req_pos
//   pos_out  registered position vector, one bit per servo
//   busy     registered per-servo settling flags
//   idle     queue empty and no servo settling
// -----------------------------------------------------------------------------
module servo_move_scheduler #(
   parameter int                    NUM_SERVOS    = 8,
   parameter int                    FIFO_DEPTH    = 4,
   parameter int                    SETTLE_CYCLES = 25000000,
   parameter int                    MAX_ACTIVE    = 2,
   parameter logic [NUM_SERVOS-1:0] RESET_POS     = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   servo_move_scheduler_if.slave req,
   output logic [NUM_SERVOS-1:0] pos_out,
   output logic [NUM_SERVOS-1:0] busy,
   output logic                  idle
);

   localparam int IW = (NUM_SERVOS > 1) ? $clog2(NUM_SERVOS) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int AW = $clog2(NUM_SERVOS + 1);

   localparam logic [TW-1:0] TIMER_LOAD   = TW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] FULL_COUNT   = CW'(FIFO_DEPTH);
   localparam logic [AW-1:0] ACTIVE_LIMIT = AW'(MAX_ACTIVE);

   // ---------------------------------------------------------------- queue
   // Entry layout: {idx, pos}. The head is read combinationally so that a
   // push into an empty queue is seen by dispatch on the very next cycle.
   logic [IW:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;

   logic ready;
   logic push;
   logic pop;
   logic issue;

   // Ready depends only on the registered occupancy, so a pop from a full
   // queue frees a slot that becomes usable one cycle later.
   assign ready         = (count_reg != FULL_COUNT);
   assign req.req_ready = ready;
   assign push          = req.req_valid && ready;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= {req.req_idx, req.req_pos};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // ------------------------------------------------------------- dispatch
   logic [NUM_SERVOS-1:0] pos_reg;
   logic [NUM_SERVOS-1:0] busy_reg;
   logic [TW-1:0]         timer_reg [NUM_SERVOS];

   logic          head_valid;
   logic [IW-1:0] head_idx;
   logic          head_pos;
   logic          head_noop;
   logic [AW-1:0] active_cnt;

   assign head_valid = (count_reg != '0);
   assign head_idx   = fifo_mem[rd_ptr_reg][IW:1];
   assign head_pos   = fifo_mem[rd_ptr_reg][0];
   assign head_noop  = (head_pos == pos_reg[head_idx]);

   always_comb begin
      active_cnt = '0;
      for (int i = 0; i < NUM_SERVOS; i++) begin
         active_cnt = active_cnt + AW'(busy_reg[i]);
      end
   end

   // A head that cannot issue blocks everything behind it; requests are
   // never reordered around a stalled servo.
   always_comb begin
      issue = 1'b0;
      pop   = 1'b0;
      if (head_valid) begin
         if (head_noop) begin
            pop = 1'b1;
         end else if (!busy_reg[head_idx] && (active_cnt < ACTIVE_LIMIT)) begin
            issue = 1'b1;
            pop   = 1'b1;
         end
      end
   end

   // ------------------------------------------------- per-servo state
   // Issue only happens on a non-busy servo, so load and countdown never
   // collide. busy stays high for SETTLE_CYCLES cycles: loaded with N-1 and
   // cleared on the edge that sees zero.
   generate
      for (genvar gi = 0; gi < NUM_SERVOS; gi++) begin : g_servo
         logic sel;
         assign sel = issue && (head_idx == IW'(gi));

         always_ff @(posedge clk) begin
            if (rst) begin
               pos_reg[gi]   <= RESET_POS[gi];
               busy_reg[gi]  <= 1'b0;
               timer_reg[gi] <= '0;
            end else if (sel) begin
               pos_reg[gi]   <= head_pos;
               busy_reg[gi]  <= 1'b1;
               timer_reg[gi] <= TIMER_LOAD;
            end else if (busy_reg[gi]) begin
               if (timer_reg[gi] == '0) begin
                  busy_reg[gi] <= 1'b0;
               end else begin
                  timer_reg[gi] <= timer_reg[gi] - 1'b1;
               end
            end
         end
      end
   endgenerate

   assign pos_out = pos_reg;
   assign busy    = busy_reg;
   assign idle    = (count_reg == '0) && (busy_reg == '0);

endmodule

// File: tb/tb_servo_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_servo_move_scheduler
// Directed table of per-cycle stimulus with hand-computed expected outputs,
// plus a hand-written sequence for reset during activity.
// Settle time 8 cycles, at most 2 servos active.
// -----------------------------------------------------------------------------
module tb_servo_move_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pos_out;
   logic [7:0] busy;
   logic       idle;

   int errors = 0;
   int checks = 0;

   servo_move_scheduler_if #(.IDX_W(3)) bus ();

   servo_move_scheduler #(
      .NUM_SERVOS    (8),
      .FIFO_DEPTH    (4),
      .SETTLE_CYCLES (8),
      .MAX_ACTIVE    (2),
      .RESET_POS     (8'h00)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.slave),
      .pos_out (pos_out),
      .busy    (busy),
      .idle    (idle)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   // One record per clock edge: inputs applied before the edge, outputs
   // expected just after it.
   typedef struct {
      logic       v;
      logic [2:0] idx;
      logic       pos;
      logic [7:0] epos;
      logic [7:0] ebusy;
      logic       erdy;
      logic       eidle;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic v, input logic [2:0] idx, input logic p,
                               input logic [7:0] ep, input logic [7:0] eb,
                               input logic er, input logic ei);
      vec_t r;
      r.v = v; r.idx = idx; r.pos = p;
      r.epos = ep; r.ebusy = eb; r.erdy = er; r.eidle = ei;
      vecs.push_back(r);
   endfunction

   function automatic void addn(input int n, input logic v, input logic [2:0] idx,
                                input logic p, input logic [7:0] ep,
                                input logic [7:0] eb, input logic er, input logic ei);
      for (int k = 0; k < n; k++) add(v, idx, p, ep, eb, er, ei);
   endfunction

   task automatic chk(input string name, input int row,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h required %0h", name, row, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] idx, input logic p);
      bus.req_valid = v;
      bus.req_idx   = idx;
      bus.req_pos   = p;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---- scenario 1: single move, full settle window
      add (1, 3, 1, 8'h00, 8'h00, 1, 0);
      add (0, 0, 0, 8'h08, 8'h08, 1, 0);
      addn(7, 0, 0, 0, 8'h08, 8'h08, 1, 0);
      add (0, 0, 0, 8'h08, 8'h00, 1, 1);
      // ---- scenario 2: three back-to-back, third held by active cap
      add (1, 0, 1, 8'h08, 8'h00, 1, 0);
      add (1, 1, 1, 8'h09, 8'h01, 1, 0);
      add (1, 2, 1, 8'h0B, 8'h03, 1, 0);
      addn(6, 0, 0, 0, 8'h0B, 8'h03, 1, 0);
      add (0, 0, 0, 8'h0B, 8'h02, 1, 0);
      add (0, 0, 0, 8'h0F, 8'h04, 1, 0);
      addn(7, 0, 0, 0, 8'h0F, 8'h04, 1, 0);
      add (0, 0, 0, 8'h0F, 8'h00, 1, 1);
      // ---- scenario 3: no-op request
      add (1, 5, 0, 8'h0F, 8'h00, 1, 0);
      add (0, 0, 0, 8'h0F, 8'h00, 1, 1);
      // ---- scenario 4: same servo twice, serialised
      add (1, 4, 1, 8'h0F, 8'h00, 1, 0);
      add (1, 4, 0, 8'h1F, 8'h10, 1, 0);
      addn(7, 0, 0, 0, 8'h1F, 8'h10, 1, 0);
      add (0, 0, 0, 8'h1F, 8'h00, 1, 0);
      add (0, 0, 0, 8'h0F, 8'h10, 1, 0);
      addn(7, 0, 0, 0, 8'h0F, 8'h10, 1, 0);
      add (0, 0, 0, 8'h0F, 8'h00, 1, 1);
      // ---- scenario 5: fill behind a stalled head, hold valid while full
      add (1, 6, 1, 8'h0F, 8'h00, 1, 0);
      add (1, 6, 0, 8'h4F, 8'h40, 1, 0);
      add (1, 0, 0, 8'h4F, 8'h40, 1, 0);
      add (1, 1, 0, 8'h4F, 8'h40, 1, 0);
      add (1, 2, 0, 8'h4F, 8'h40, 0, 0);
      addn(4, 1, 3, 0, 8'h4F, 8'h40, 0, 0);
      add (1, 3, 0, 8'h4F, 8'h00, 0, 0);
      add (1, 3, 0, 8'h0F, 8'h40, 1, 0);
      add (1, 3, 0, 8'h0E, 8'h41, 1, 0);
      addn(6, 0, 0, 0, 8'h0E, 8'h41, 1, 0);
      add (0, 0, 0, 8'h0E, 8'h01, 1, 0);
      add (0, 0, 0, 8'h0C, 8'h02, 1, 0);
      add (0, 0, 0, 8'h08, 8'h06, 1, 0);
      addn(6, 0, 0, 0, 8'h08, 8'h06, 1, 0);
      add (0, 0, 0, 8'h08, 8'h04, 1, 0);
      add (0, 0, 0, 8'h00, 8'h08, 1, 0);
      addn(7, 0, 0, 0, 8'h00, 8'h08, 1, 0);
      add (0, 0, 0, 8'h00, 8'h00, 1, 1);

      // ---- reset
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_idx   = '0;
      bus.req_pos   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_pos",   0, 32'(pos_out), 32'h00);
      chk("reset_busy",  0, 32'(busy), 32'h00);
      chk("reset_ready", 0, 32'(bus.req_ready), 32'h1);
      chk("reset_idle",  0, 32'(idle), 32'h1);
      rst = 1'b0;

      // ---- table
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].v, vecs[i].idx, vecs[i].pos);
         $display("row %0d v=%0b idx=%0d pos=%0b -> pos_out=%02h busy=%02h ready=%0b idle=%0b",
                  i, vecs[i].v, vecs[i].idx, vecs[i].pos, pos_out, busy, bus.req_ready, idle);
         chk("pos_out",    i, 32'(pos_out), 32'(vecs[i].epos));
         chk("busy",       i, 32'(busy), 32'(vecs[i].ebusy));
         chk("req_ready",  i, 32'(bus.req_ready), 32'(vecs[i].erdy));
         chk("idle",       i, 32'(idle), 32'(vecs[i].eidle));
         chk("active_cap", i, 32'($countones(busy) <= 2), 32'h1);
      end

      // ---- scenario 6: reset with two servos busy and three requests queued
      drive(1, 0, 1);
      drive(1, 1, 1);
      drive(1, 2, 1);
      drive(1, 3, 1);
      drive(1, 4, 1);
      $display("pre-reset pos_out=%02h busy=%02h ready=%0b idle=%0b", pos_out, busy, bus.req_ready, idle);
      chk("prerst_pos",  100, 32'(pos_out), 32'h03);
      chk("prerst_busy", 100, 32'(busy), 32'h03);
      chk("prerst_idle", 100, 32'(idle), 32'h0);
      bus.req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      $display("post-reset pos_out=%02h busy=%02h ready=%0b idle=%0b", pos_out, busy, bus.req_ready, idle);
      chk("rst_pos",   101, 32'(pos_out), 32'h00);
      chk("rst_busy",  101, 32'(busy), 32'h00);
      chk("rst_idle",  101, 32'(idle), 32'h1);
      chk("rst_ready", 101, 32'(bus.req_ready), 32'h1);
      for (int c = 0; c < 20; c++) begin
         drive(0, 0, 0);
         $display("after-reset cycle %0d pos_out=%02h busy=%02h idle=%0b", c, pos_out, busy, idle);
         chk("dropped_pos",  102 + c, 32'(pos_out), 32'h00);
         chk("dropped_busy", 102 + c, 32'(busy), 32'h00);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
